seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector, successor to the fixed 7-state detector FSM. Samples one serial bit per qualified clock. Pulses Z on each occurrence of a DET_W-bit detect pattern and counts the matches. Asserts a sticky error E on a ERR_W-bit error pattern. Unlike the fixed version, it adds a valid qualifier, an overlap mode, a saturating match counter and a synchronous clear to leave the error dead-end state.

Parameters:
- DET_W, 3, detect pattern length in bits (1..16).
- DET_PATTERN, 3'b110, detect pattern; MSB is the first-received bit.
- ERR_W, 5, error pattern length in bits (1..16).
- ERR_PATTERN, 5'b11001, error pattern; MSB is the first-received bit.
- OVERLAP, 1, 1 = overlapping detection; 0 = non-overlapping.
- CNT_W, 8, match counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- arstn  in  1  asynchronous active-low reset.
- data  in  1  serial input bit.
- data_valid  in  1  data is sampled only when 1.
- clr  in  1  synchronous clear; exits LOCKED.
- E  out  1  sticky error flag (registered).
- Z  out  1  one-cycle detect pulse (registered).
- match_count  out  CNT_W  saturating count of Z pulses.
- locked  out  1  1 while the FSM is in LOCKED.

Behaviour:
- Reset (arstn=0, asynchronous): state=RUN; both histories and fill counters 0; E=0, Z=0, match_count=0, locked=0.
- States: RUN and LOCKED.
- RUN, on a sample (data_valid=1):
  - Shift data into det_hist (DET_W bits) and err_hist (ERR_W bits), newest bit at LSB.
  - Each history has its own fill counter, saturating at its width.
- Detect match: det fill == DET_W and the new det_hist == DET_PATTERN.
- Error match: err fill == ERR_W and the new err_hist == ERR_PATTERN.
- Latency: Z and E are visible in the cycle after the edge that sampled the final pattern bit. Moore-style, one cycle.
- On a detect match (no error match):
  - Z=1 for exactly one cycle.
  - match_count increments, saturating at 2^CNT_W-1 (no wrap).
  - If OVERLAP=0, the det fill counter clears to 0, so the next match needs DET_W fresh bits.
  - The error history is never cleared by a detect match.
- On an error match: state goes to LOCKED, E=1, locked=1.
  - If a detect match occurs on the same sample, E has priority: Z stays 0 and the count is unchanged.
- data_valid=0: no shift, Z=0, all state held.
- LOCKED is a dead end:
  - data and data_valid are ignored.
  - E stays 1, Z stays 0, match_count is frozen.
- clr=1, in either state: next cycle state=RUN; histories, fill counters, E, Z and match_count all go to 0.
  - clr has priority over a sample in the same cycle; that sample is discarded.
- Reset mid-pattern: partial history is lost; detection restarts from an empty history.
- With default parameters the block reproduces the fixed detector:
  - Z follows "110".
  - E locks after "11001".

Decomposition:
- Shared package seq_det_pkg holds:
  - the state encoding constants ST_RUN and ST_LOCKED;
  - the default pattern constants DET_PATTERN_DEF and ERR_PATTERN_DEF.
- Sub-module shift_matcher (parameters W, PATTERN, CAN_FLUSH) implements one history register, its fill counter and the match compare. It is instantiated twice: detect with flush = !OVERLAP, error with no flush.
- Top level holds the FSM, Z/E registers and the counter.

Test Plan:
- Default vector, LSB-first, data_valid=1 throughout: 1,1,1,0,1,1,1,0,1,0,1,1,1,1,0,0,1,0,1,0,0,1,0,0.
  - Z pulses after sample 4, sample 8 and sample 15; match_count=3.
  - E=1 and locked=1 from the cycle after sample 17.
  - Later samples leave E=1, Z=0 and match_count=3.
- Lock then clr, with the above sequence: after the lock, clr=1 for one cycle.
  - Next cycle E=0, locked=0, match_count=0.
  - Then 1,1,0 gives Z=1 after the 0 and match_count=1.
- OVERLAP=0, DET_W=2, DET_PATTERN=2'b11, input 1,1,1,1: Z after sample 2 and sample 4; match_count=2.
  - The same input with OVERLAP=1 gives Z after samples 2, 3 and 4; match_count=3.
- data_valid gaps: 1, (valid=0 ×3), 1, (valid=0), 0.
  - Exactly one Z, in the cycle after the final 0.
  - Z=0 during all gap cycles.
- Saturation: CNT_W=2, 5 detect matches.
  - match_count reads 1, 2, 3, 3, 3.
- Async reset: assert arstn=0 mid-period after input 1,1.
  - All outputs 0 immediately.
  - After release, 0 alone gives no Z; a fresh 1,1,0 gives Z.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised serial pattern detector:
// FSM state encoding and the default detect/error patterns.
package seq_det_pkg;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [2:0] DET_PATTERN_DEF = 3'b110;
  localparam logic [4:0] ERR_PATTERN_DEF = 5'b11001;

endpackage

// File: rtl/shift_matcher.sv
// One serial history register with a saturating fill counter. match_o flags
// that the bit being shifted in completes PATTERN (newest bit at LSB).
module shift_matcher #(
  parameter int           W         = 3,
  parameter logic [W-1:0] PATTERN   = '0,
  parameter bit           CAN_FLUSH = 1'b0
) (
  input  logic clk,
  input  logic arstn,
  input  logic shift_i,
  input  logic clr_i,
  input  logic data_i,
  output logic match_o
);

  localparam int FW = $clog2(W + 1);

  logic [W-1:0]  hist_q, hist_d, shifted;
  logic [FW-1:0] fill_q, fill_d, fill_inc;

  generate
    if (W == 1) begin : g_one
      assign shifted = data_i;
    end else begin : g_many
      assign shifted = {hist_q[W-2:0], data_i};
    end
  endgenerate

  assign fill_inc = (fill_q == FW'(W)) ? fill_q : fill_q + 1'b1;
  assign match_o  = shift_i && (fill_inc == FW'(W)) && (shifted == PATTERN);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      hist_d = shifted;
      // Flushing empties the fill count so the next match needs W fresh bits.
      fill_d = (CAN_FLUSH && match_o) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial detector: pulses Z and counts detect-pattern hits, and locks with a
// sticky E on the error pattern until clr.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               DET_W       = 3,
  parameter logic [DET_W-1:0] DET_PATTERN = DET_PATTERN_DEF,
  parameter int               ERR_W       = 5,
  parameter logic [ERR_W-1:0] ERR_PATTERN = ERR_PATTERN_DEF,
  parameter bit               OVERLAP     = 1'b1,
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             data,
  input  logic             data_valid,
  input  logic             clr,
  output logic             E,
  output logic             Z,
  output logic [CNT_W-1:0] match_count,
  output logic             locked
);

  logic [0:0]       state_q, state_d;
  logic             e_q, e_d, z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sample, det_match, err_match;

  // clr wins over a same-cycle sample, and LOCKED ignores the input entirely.
  assign sample = data_valid && (state_q == ST_RUN) && !clr;

  shift_matcher #(.W(DET_W), .PATTERN(DET_PATTERN), .CAN_FLUSH(!OVERLAP)) u_det (
    .clk     (clk),
    .arstn   (arstn),
    .shift_i (sample),
    .clr_i   (clr),
    .data_i  (data),
    .match_o (det_match)
  );

  shift_matcher #(.W(ERR_W), .PATTERN(ERR_PATTERN), .CAN_FLUSH(1'b0)) u_err (
    .clk     (clk),
    .arstn   (arstn),
    .shift_i (sample),
    .clr_i   (clr),
    .data_i  (data),
    .match_o (err_match)
  );

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    z_d     = 1'b0;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ST_RUN;
      e_d     = 1'b0;
      cnt_d   = '0;
    end else if (sample) begin
      if (err_match) begin
        state_d = ST_LOCKED;
        e_d     = 1'b1;
      end else if (det_match) begin
        z_d   = 1'b1;
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_RUN;
      e_q     <= 1'b0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
    end
  end

  assign E           = e_q;
  assign Z           = z_q;
  assign match_count = cnt_q;
  assign locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default, non-overlap, overlap and
// narrow-counter instances share one stimulus stream.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic data = 1'b0;
  logic data_valid = 1'b0;
  logic clr = 1'b0;

  logic       a_e, a_z, a_lk;
  logic [7:0] a_cnt;
  logic       n_e, n_z, n_lk;
  logic [7:0] n_cnt;
  logic       o_e, o_z, o_lk;
  logic [7:0] o_cnt;
  logic       s_e, s_z, s_lk;
  logic [1:0] s_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  seq_detector_param dut_a (
    .clk(clk), .arstn(arstn), .data(data), .data_valid(data_valid), .clr(clr),
    .E(a_e), .Z(a_z), .match_count(a_cnt), .locked(a_lk)
  );

  seq_detector_param #(.DET_W(2), .DET_PATTERN(2'b11), .OVERLAP(1'b0)) dut_n (
    .clk(clk), .arstn(arstn), .data(data), .data_valid(data_valid), .clr(clr),
    .E(n_e), .Z(n_z), .match_count(n_cnt), .locked(n_lk)
  );

  seq_detector_param #(.DET_W(2), .DET_PATTERN(2'b11), .OVERLAP(1'b1)) dut_o (
    .clk(clk), .arstn(arstn), .data(data), .data_valid(data_valid), .clr(clr),
    .E(o_e), .Z(o_z), .match_count(o_cnt), .locked(o_lk)
  );

  seq_detector_param #(.CNT_W(2)) dut_s (
    .clk(clk), .arstn(arstn), .data(data), .data_valid(data_valid), .clr(clr),
    .E(s_e), .Z(s_z), .match_count(s_cnt), .locked(s_lk)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic d, input logic v, input logic c);
    @(negedge clk);
    data = d;
    data_valid = v;
    clr = c;
    @(posedge clk);
    #1;
    $display("[TB] data=%0d valid=%0d clr=%0d -> a: Z=%0d E=%0d cnt=%0d", d, v, c, a_z, a_e, a_cnt);
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    data_valid = 1'b0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arstn = 1'b1;
  endtask

  int vec [24] = '{1,1,1,0,1,1,1,0,1,0,1,1,1,1,0,0,1,0,1,0,0,1,0,0};
  int sat_exp [5] = '{1,2,3,3,3};

  initial begin
    do_reset();
    check("rst_E", a_e, 0);
    check("rst_Z", a_z, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_locked", a_lk, 0);

    // Default vector: Z after samples 4, 8, 15; lock after sample 17.
    for (int i = 0; i < 24; i++) begin
      step(vec[i][0], 1'b1, 1'b0);
      check("vec_Z", a_z, (i == 3 || i == 7 || i == 14) ? 1 : 0);
      check("vec_E", a_e, (i >= 16) ? 1 : 0);
      check("vec_locked", a_lk, (i >= 16) ? 1 : 0);
    end
    check("vec_cnt", a_cnt, 3);

    // clr exits LOCKED; its same-cycle sample is discarded.
    step(1'b1, 1'b1, 1'b1);
    check("clr_E", a_e, 0);
    check("clr_locked", a_lk, 0);
    check("clr_cnt", a_cnt, 0);
    step(1'b1, 1'b1, 1'b0);
    check("clr_Z1", a_z, 0);
    step(1'b1, 1'b1, 1'b0);
    check("clr_Z2", a_z, 0);
    step(1'b0, 1'b1, 1'b0);
    check("clr_Z3", a_z, 1);
    check("clr_cnt1", a_cnt, 1);

    // Overlap vs non-overlap on 1,1,1,1 with pattern 11.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check("novl_Z", n_z, (i == 1 || i == 3) ? 1 : 0);
      check("ovl_Z", o_z, (i >= 1) ? 1 : 0);
    end
    check("novl_cnt", n_cnt, 2);
    check("ovl_cnt", o_cnt, 3);

    // data_valid gaps: 1, gap x3, 1, gap, 0.
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("gap_Z_a", a_z, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check("gap_Z_idle", a_z, 0);
    end
    step(1'b1, 1'b1, 1'b0);
    check("gap_Z_b", a_z, 0);
    step(1'b0, 1'b0, 1'b0);
    check("gap_Z_idle2", a_z, 0);
    step(1'b0, 1'b1, 1'b0);
    check("gap_Z_hit", a_z, 1);
    check("gap_cnt", a_cnt, 1);
    step(1'b0, 1'b0, 1'b0);
    check("gap_Z_after", a_z, 0);

    // Saturation with a 2-bit counter: five "110" matches.
    step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("sat_Z", s_z, 1);
      check("sat_cnt", s_cnt, sat_exp[k]);
    end
    check("sat_wide_cnt", a_cnt, 5);

    // Async reset mid-period after a partial 1,1.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #2;
    arstn = 1'b0;
    data_valid = 1'b0;
    #1;
    check("arst_Z", a_z, 0);
    check("arst_E", a_e, 0);
    check("arst_cnt", a_cnt, 0);
    check("arst_locked", a_lk, 0);
    @(negedge clk);
    arstn = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    check("arst_noZ", a_z, 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("arst_Z_fresh", a_z, 1);
    check("arst_cnt1", a_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
